// File: rtl/draw_pkg.sv
// Shared constants for the glyph drawing engine: glyph codes, geometry,
// screen limits, colours and the engine FSM state type.
package draw_pkg;

  localparam int GLYPH_W_DEF  = 10;
  localparam int GLYPH_H_DEF  = 14;
  localparam int SCREEN_W_DEF = 320;
  localparam int SCREEN_H_DEF = 240;

  localparam logic [2:0] COLOUR_FG = 3'b111;
  localparam logic [2:0] COLOUR_BG = 3'b000;

  localparam logic [4:0] GLYPH_A = 5'd15;
  localparam logic [4:0] GLYPH_E = 5'd17;
  localparam logic [4:0] GLYPH_F = 5'd18;
  localparam logic [4:0] GLYPH_I = 5'd20;
  localparam logic [4:0] GLYPH_L = 5'd21;
  localparam logic [4:0] GLYPH_V = 5'd28;
  localparam logic [4:0] GLYPH_D = 5'd30;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAW  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } draw_state_e;

endpackage

// File: rtl/glyph_rom.sv
// Registered glyph bitmap ROM. Address is {type, row}; data MSB is the
// leftmost pixel. Codes without a bitmap read as all-zero rows.
module glyph_rom
  import draw_pkg::*;
#(
  parameter int W = GLYPH_W_DEF
) (
  input  logic         clk,
  input  logic [8:0]   addr_i,
  output logic [W-1:0] data_o
);

  logic [4:0] glyph;
  logic [3:0] row;
  logic [9:0] row_bits;

  assign glyph = addr_i[8:4];
  assign row   = addr_i[3:0];

  always_comb begin
    row_bits = '0;
    case (glyph)
      GLYPH_L: begin
        if (row inside {[4'd1:4'd11]}) row_bits = 10'b0110000000;
        else if (row == 4'd12)         row_bits = 10'b0111111110;
      end
      GLYPH_I: begin
        if (row == 4'd1 || row == 4'd12)    row_bits = 10'b0111111110;
        else if (row inside {[4'd2:4'd11]}) row_bits = 10'b0000110000;
      end
      GLYPH_E: begin
        if (row == 4'd1 || row == 4'd12)    row_bits = 10'b0111111110;
        else if (row == 4'd6)               row_bits = 10'b0111111000;
        else if (row inside {[4'd2:4'd11]}) row_bits = 10'b0110000000;
      end
      GLYPH_F: begin
        if (row == 4'd1)                    row_bits = 10'b0111111110;
        else if (row == 4'd6)               row_bits = 10'b0111111000;
        else if (row inside {[4'd2:4'd12]}) row_bits = 10'b0110000000;
      end
      GLYPH_A: begin
        if (row == 4'd1)                    row_bits = 10'b0001111000;
        else if (row == 4'd2)               row_bits = 10'b0011001100;
        else if (row == 4'd7)               row_bits = 10'b0111111110;
        else if (row inside {[4'd3:4'd12]}) row_bits = 10'b0110000110;
      end
      GLYPH_V: begin
        if (row inside {[4'd1:4'd8]})       row_bits = 10'b0110000110;
        else if (row inside {[4'd9:4'd10]}) row_bits = 10'b0011001100;
        else if (row == 4'd11)              row_bits = 10'b0001111000;
        else if (row == 4'd12)              row_bits = 10'b0000110000;
      end
      GLYPH_D: begin
        if (row == 4'd1 || row == 4'd12)       row_bits = 10'b0111111000;
        else if (row == 4'd2 || row == 4'd11)  row_bits = 10'b0110001100;
        else if (row inside {[4'd3:4'd10]})    row_bits = 10'b0110000110;
      end
      default: row_bits = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    data_o <= W'(row_bits);
  end

endmodule

// File: rtl/draw_glyph_engine.sv
// Rasterises one glyph per start_draw command into the VGA write port,
// one pixel per clock through a single ROM pipeline stage.
module draw_glyph_engine
  import draw_pkg::*;
#(
  parameter int         GLYPH_W     = GLYPH_W_DEF,
  parameter int         GLYPH_H     = GLYPH_H_DEF,
  parameter logic [2:0] FG_COLOUR   = COLOUR_FG,
  parameter logic [2:0] BG_COLOUR   = COLOUR_BG,
  parameter bit         TRANSPARENT = 1'b0,
  parameter int         SCREEN_W    = SCREEN_W_DEF,
  parameter int         SCREEN_H    = SCREEN_H_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start_draw,
  input  logic [8:0] x_in,
  input  logic [7:0] y_in,
  input  logic [4:0] object_type,
  output logic [8:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       draw_object_done
);

  localparam int CW = $clog2(GLYPH_W);

  draw_state_e   state_q;
  logic [CW-1:0] col_q;
  logic [3:0]    row_q;
  logic [8:0]    xb_q;
  logic [7:0]    yb_q;
  logic [4:0]    type_q;
  logic          done_q;

  // Pipeline stage aligned with the registered ROM output.
  logic          pv_q;
  logic [9:0]    px_q;
  logic [8:0]    py_q;
  logic [CW-1:0] pcol_q;

  logic [GLYPH_W-1:0] rom_row;
  logic               pix;
  logic               in_screen;

  glyph_rom #(.W(GLYPH_W)) u_rom (
    .clk    (clk),
    .addr_i ({type_q, row_q}),
    .data_o (rom_row)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      xb_q    <= '0;
      yb_q    <= '0;
      type_q  <= '0;
      done_q  <= 1'b0;
      pv_q    <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
      pcol_q  <= '0;
    end else begin
      pv_q   <= (state_q == ST_DRAW);
      px_q   <= {1'b0, xb_q} + 10'(col_q);
      py_q   <= {1'b0, yb_q} + 9'(row_q);
      pcol_q <= col_q;
      case (state_q)
        ST_IDLE: begin
          if (start_draw) begin
            xb_q    <= x_in;
            yb_q    <= y_in;
            type_q  <= object_type;
            col_q   <= '0;
            row_q   <= '0;
            state_q <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          if (col_q == CW'(GLYPH_W - 1)) begin
            col_q <= '0;
            if (row_q == 4'(GLYPH_H - 1)) state_q <= ST_FLUSH;
            else                          row_q   <= row_q + 4'd1;
          end else begin
            col_q <= col_q + CW'(1);
          end
        end
        ST_FLUSH: begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
        end
        ST_DONE: begin
          if (!start_draw) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Off-screen and transparent pixels still take their cycle; only the strobe drops.
  assign pix       = rom_row[CW'(GLYPH_W - 1) - pcol_q];
  assign in_screen = (px_q < 10'(SCREEN_W)) && (py_q < 9'(SCREEN_H));

  assign vga_x            = px_q[8:0];
  assign vga_y            = py_q[7:0];
  assign vga_colour       = pv_q ? (pix ? FG_COLOUR : BG_COLOUR) : 3'b000;
  assign vga_plot         = pv_q && in_screen && (pix || !TRANSPARENT);
  assign draw_object_done = done_q;

endmodule

// File: tb/tb_draw_glyph_engine.sv
// Bench for draw_glyph_engine: opaque and transparent instances share the
// command inputs; plots are compared against a bitmap-art reference model.
module tb_draw_glyph_engine;

  localparam int EW = 52;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start_draw;
  logic [8:0] x_in;
  logic [7:0] y_in;
  logic [4:0] object_type;

  logic [8:0] vx0, vx1;
  logic [7:0] vy0, vy1;
  logic [2:0] vc0, vc1;
  logic       vp0, vp1, dn0, dn1;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q0[$], exp_q1[$], obs_q0[$], obs_q1[$];
  string rows[32][14];

  draw_glyph_engine #(.TRANSPARENT(1'b0)) dut0 (
    .clk(clk), .resetn(resetn), .start_draw(start_draw), .x_in(x_in), .y_in(y_in),
    .object_type(object_type), .vga_x(vx0), .vga_y(vy0), .vga_colour(vc0),
    .vga_plot(vp0), .draw_object_done(dn0)
  );

  draw_glyph_engine #(.TRANSPARENT(1'b1)) dut1 (
    .clk(clk), .resetn(resetn), .start_draw(start_draw), .x_in(x_in), .y_in(y_in),
    .object_type(object_type), .vga_x(vx1), .vga_y(vy1), .vga_colour(vc1),
    .vga_plot(vp1), .draw_object_done(dn1)
  );

  // clock / cycle counter / plot monitor
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (vp0) obs_q0.push_back({32'(cyc), vx0, vy0, vc0});
    if (vp1) obs_q1.push_back({32'(cyc), vx1, vy1, vc1});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put_rows(input int t, input int r0, input int r1, input string s);
    for (int r = r0; r <= r1; r++) rows[t][r] = s;
  endtask

  function automatic bit art_bit(input int t, input int r, input int c);
    string s;
    byte   ch;
    s = rows[t][r];
    if (s.len() != 10) return 1'b0;
    ch = s[c];
    return (ch == 8'h23);
  endfunction

  // Reference: every cell of the 10x14 bitmap takes one cycle, plot k visible k+1 cycles after latch.
  task automatic model_push(input int l, input int x, input int y, input int t);
    logic [EW-1:0] e;
    bit b;
    int px, py;
    for (int r = 0; r < 14; r++) begin
      for (int c = 0; c < 10; c++) begin
        b  = art_bit(t, r, c);
        px = x + c;
        py = y + r;
        if (px < 320 && py < 240) begin
          e = {32'(l + 1 + r * 10 + c), 9'(px), 8'(py), (b ? 3'b111 : 3'b000)};
          exp_q0.push_back(e);
          if (b) exp_q1.push_back(e);
        end
      end
    end
  endtask

  task automatic compare_queues(input string tag);
    int n;
    check({tag, "_count_opaque"}, obs_q0.size(), exp_q0.size());
    check({tag, "_count_transp"}, obs_q1.size(), exp_q1.size());
    n = (obs_q0.size() < exp_q0.size()) ? obs_q0.size() : exp_q0.size();
    for (int i = 0; i < n; i++) check({tag, "_pix_opaque"}, obs_q0[i], exp_q0[i]);
    n = (obs_q1.size() < exp_q1.size()) ? obs_q1.size() : exp_q1.size();
    for (int i = 0; i < n; i++) check({tag, "_pix_transp"}, obs_q1[i], exp_q1[i]);
    obs_q0.delete(); obs_q1.delete(); exp_q0.delete(); exp_q1.delete();
  endtask

  // driver: called at a negedge with the engines idle and start_draw low
  task automatic run_cmd(input string tag, input int x, input int y, input int t,
                         input bit early_drop, input int extra_hold);
    int l, seen;
    x_in = 9'(x); y_in = 8'(y); object_type = 5'(t); start_draw = 1'b1;
    l = cyc + 1;
    model_push(l, x, y, t);
    @(negedge clk);
    if (early_drop) start_draw = 1'b0;
    x_in = 9'($urandom); y_in = 8'($urandom); object_type = 5'($urandom);
    seen = -1;
    for (int i = 0; i < 300 && seen < 0; i++) begin
      if (dn0) seen = cyc;
      else begin
        @(negedge clk);
        x_in = 9'($urandom); y_in = 8'($urandom); object_type = 5'($urandom);
      end
    end
    check({tag, "_done_edge"}, seen, l + 141);
    check({tag, "_done_transp"}, dn1, 1'b1);
    if (!early_drop) begin
      for (int i = 0; i < extra_hold; i++) begin
        @(negedge clk);
        check({tag, "_done_held"}, {dn0, dn1}, 2'b11);
      end
      start_draw = 1'b0;
    end
    @(negedge clk);
    check({tag, "_done_release"}, {dn0, dn1}, 2'b00);
    compare_queues(tag);
  endtask

  initial begin
    int seq_t[11] = '{21, 17, 28, 17, 21, 18, 15, 20, 21, 17, 30};
    int codes[7]  = '{15, 17, 18, 20, 21, 28, 30};
    int t;

    put_rows(21, 1, 11, ".##.......");  put_rows(21, 12, 12, ".########.");
    put_rows(20, 1, 1, ".########.");   put_rows(20, 2, 11, "....##....");
    put_rows(20, 12, 12, ".########.");
    put_rows(17, 1, 1, ".########.");   put_rows(17, 2, 11, ".##.......");
    put_rows(17, 6, 6, ".######...");   put_rows(17, 12, 12, ".########.");
    put_rows(18, 1, 1, ".########.");   put_rows(18, 2, 12, ".##.......");
    put_rows(18, 6, 6, ".######...");
    put_rows(15, 1, 1, "...####...");   put_rows(15, 2, 2, "..##..##..");
    put_rows(15, 3, 12, ".##....##.");  put_rows(15, 7, 7, ".########.");
    put_rows(28, 1, 8, ".##....##.");   put_rows(28, 9, 10, "..##..##..");
    put_rows(28, 11, 11, "...####...");  put_rows(28, 12, 12, "....##....");
    put_rows(30, 1, 1, ".######...");   put_rows(30, 2, 2, ".##...##..");
    put_rows(30, 3, 10, ".##....##.");  put_rows(30, 11, 11, ".##...##..");
    put_rows(30, 12, 12, ".######...");

    resetn = 1'b0; start_draw = 1'b0; x_in = '0; y_in = '0; object_type = '0;
    @(negedge clk);
    check("reset_opaque", {vx0, vy0, vc0, vp0, dn0}, 22'd0);
    check("reset_transp", {vx1, vy1, vc1, vp1, dn1}, 22'd0);
    resetn = 1'b1;
    @(negedge clk);

    run_cmd("single_L", 121, 91, 21, 1'b0, 3);

    for (int i = 0; i < 11; i++)
      run_cmd("level_failed", (i < 5) ? 121 + 10 * i : 121 + 10 * (i - 5),
              (i < 5) ? 91 : 115, seq_t[i], 1'b0, 0);

    run_cmd("clip_A", 315, 230, 15, 1'b0, 0);
    run_cmd("glyph_I", 121, 91, 20, 1'b0, 1);
    run_cmd("undefined", 40, 40, 3, 1'b0, 0);
    run_cmd("early_drop", 200, 100, 30, 1'b1, 0);

    // abort mid-draw with an asynchronous reset
    x_in = 9'd10; y_in = 8'd10; object_type = 5'd17; start_draw = 1'b1;
    repeat (50) @(negedge clk);
    check("pre_reset_plot", vp0, 1'b1);
    #2 resetn = 1'b0;
    #1;
    check("async_reset_opaque", {vx0, vy0, vc0, vp0, dn0}, 22'd0);
    check("async_reset_transp", {vx1, vy1, vc1, vp1, dn1}, 22'd0);
    obs_q0.delete(); obs_q1.delete();
    @(negedge clk);
    start_draw = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("post_reset_quiet", obs_q0.size() + obs_q1.size(), 0);
    check("post_reset_done", {dn0, dn1}, 2'b00);
    run_cmd("after_reset", 0, 0, 15, 1'b0, 0);

    for (int i = 0; i < 8; i++) begin
      t = ($urandom_range(0, 1) == 1) ? codes[$urandom_range(0, 6)] : $urandom_range(0, 31);
      run_cmd("random", $urandom_range(0, 511), $urandom_range(0, 255), t,
              1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
